sa_sequencer: RTL and testbench

//  Control FSM for the systolic tile. Replaces the hand-driven buffer/array enables with a

---
 rtl/sa_seq_pkg.sv | 22 ++
 rtl/sa_beat_counter.sv | 32 +++
 rtl/sa_sequencer.sv | 135 +++++++++++++
 tb/tb_sa_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_seq_pkg.sv
// Shared types and constants for the systolic tile sequencer.
// State encoding, counter width helper and default array geometry.
package sa_seq_pkg;

   localparam int DEF_ROWS  = 8;
   localparam int DEF_COLS  = 8;
   localparam int DEF_K_MAX = 256;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      DONE
   } seq_state_e;

   // Bits needed to hold every value 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sa_beat_counter.sv
// Loadable up-counter with clear, enable and terminal-count flag.
// Shared by every sequencer phase; tc compares against a per-phase terminal value.
module sa_beat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         tc
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == term);

endmodule

// File: rtl/sa_sequencer.sv
// Start/done job sequencer for the systolic tile: weight load, skewed stream, drain.
// Optional SA_SEQ_WEIGHT_REUSE_EN adds reuse_w to skip LOAD_W when weights are still valid.
module sa_sequencer
   import sa_seq_pkg::*;
#(
   parameter int ROWS      = DEF_ROWS,
   parameter int COLS      = DEF_COLS,
   parameter int K_MAX     = DEF_K_MAX,
   parameter int ARRAY_LAT = ROWS + COLS - 1,
   parameter int KW        = $clog2(K_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] k_len,
   input  logic          abort,
   input  logic          out_ready,
`ifdef SA_SEQ_WEIGHT_REUSE_EN
   input  logic          reuse_w,
`endif
   output logic          busy,
   output logic          done,
   output logic          cfg_err,
   output logic          weight_buffer_out_en,
   output logic          write_weight_en,
   output logic          input_buffer_out_en,
   output logic          output_buffer_load_en,
   output logic          output_buffer_out_en,
   output logic          out_valid
);

   localparam int CW = cnt_w(ARRAY_LAT + K_MAX);

   seq_state_e    state, nxt;
   logic [KW-1:0] k_q;
   logic          cfg_err_q, cfg_err_d;
   logic [CW-1:0] cnt, term;
   logic          tc, cnt_en, cnt_clr;
   logic          k_ok, reuse_ok;

   assign k_ok = (k_len != '0) && (k_len <= KW'(K_MAX));

`ifdef SA_SEQ_WEIGHT_REUSE_EN
   logic w_valid;
   assign reuse_ok = reuse_w & w_valid;
`else
   assign reuse_ok = 1'b0;
`endif

   // Terminal count per phase; the shared counter restarts at 0 on every state entry.
   always_comb begin
      case (state)
         LOAD_W:  term = CW'(ROWS - 1);
         STREAM:  term = CW'(ARRAY_LAT) + CW'(k_q) - CW'(1);
         DRAIN:   term = CW'(k_q) - CW'(1);
         default: term = '0;
      endcase
   end

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      nxt       = state;
      cnt_en    = 1'b0;
      cfg_err_d = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (k_ok) nxt = reuse_ok ? STREAM : LOAD_W;
               else      cfg_err_d = 1'b1;
            end
         end
         LOAD_W: begin
            cnt_en = 1'b1;
            if (tc) nxt = STREAM;
         end
         STREAM: begin
            cnt_en = 1'b1;
            if (tc) nxt = DRAIN;
         end
         DRAIN: begin
            cnt_en = out_ready;
            if (out_ready && tc) nxt = DONE;
         end
         default: nxt = IDLE;
      endcase
      if (abort && state != IDLE) begin
         nxt    = IDLE;
         cnt_en = 1'b0;
      end
   end

   assign cnt_clr = (nxt != state);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         k_q       <= '0;
         cfg_err_q <= 1'b0;
`ifdef SA_SEQ_WEIGHT_REUSE_EN
         w_valid   <= 1'b0;
`endif
      end else begin
         state     <= nxt;
         cfg_err_q <= cfg_err_d;
         if (state == IDLE && start && k_ok) k_q <= k_len;
`ifdef SA_SEQ_WEIGHT_REUSE_EN
         if (abort && state != IDLE)       w_valid <= 1'b0;
         else if (state == LOAD_W && tc)   w_valid <= 1'b1;
`endif
      end
   end

   sa_beat_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (cnt_en),
      .term     (term),
      .count    (cnt),
      .tc       (tc)
   );

   assign busy                  = (state != IDLE);
   assign done                  = (state == DONE);
   assign cfg_err               = cfg_err_q;
   assign weight_buffer_out_en  = (state == LOAD_W);
   assign write_weight_en       = (state == LOAD_W);
   assign input_buffer_out_en   = (state == STREAM) && (cnt < CW'(k_q));
   assign output_buffer_load_en = (state == STREAM) && (cnt >= CW'(ARRAY_LAT));
   assign out_valid             = (state == DRAIN);
   assign output_buffer_out_en  = out_valid & out_ready;

endmodule

// File: tb/tb_sa_sequencer.sv
// Self-checking bench for sa_sequencer (ROWS=COLS=4, K_MAX=16, ARRAY_LAT=7).
// Honours SA_SEQ_WEIGHT_REUSE_EN when defined.
module tb_sa_sequencer;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int K_MAX = 16;
   localparam int LAT   = ROWS + COLS - 1;
   localparam int KW    = 5;

   logic          clk = 1'b0;
   logic          rst, start, abort, out_ready, reuse_w;
   logic [KW-1:0] k_len;
   logic busy, done, cfg_err, weight_buffer_out_en, write_weight_en;
   logic input_buffer_out_en, output_buffer_load_en, output_buffer_out_en, out_valid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sa_sequencer #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .k_len                 (k_len),
      .abort                 (abort),
      .out_ready             (out_ready),
`ifdef SA_SEQ_WEIGHT_REUSE_EN
      .reuse_w               (reuse_w),
`endif
      .busy                  (busy),
      .done                  (done),
      .cfg_err               (cfg_err),
      .weight_buffer_out_en  (weight_buffer_out_en),
      .write_weight_en       (write_weight_en),
      .input_buffer_out_en   (input_buffer_out_en),
      .output_buffer_load_en (output_buffer_load_en),
      .output_buffer_out_en  (output_buffer_out_en),
      .out_valid             (out_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a job becomes a list of per-cycle enable slots (load beats, then stream
   // slots), followed by k beats to drain and one done cycle.
   typedef struct packed {
      logic wen;
      logic iben;
      logic olen;
      logic last_load;
   } slot_t;

   slot_t sched[$];
   int    drain_left = 0;
   int    k_m = 0;
   bit    done_now = 0, cfg_now = 0, wv_m = 0;

   task automatic model_step();
      slot_t s;
      bit    was_busy, dn, cf, ru;
      dn = 0;
      cf = 0;
`ifdef SA_SEQ_WEIGHT_REUSE_EN
      ru = reuse_w;
`else
      ru = 0;
`endif
      was_busy = (sched.size() != 0) || (drain_left != 0) || done_now;
      if (was_busy && abort) begin
         sched.delete();
         drain_left = 0;
         wv_m = 0;
      end else if (sched.size() != 0) begin
         s = sched.pop_front();
         if (s.last_load) wv_m = 1;
         if (sched.size() == 0) drain_left = k_m;
      end else if (drain_left != 0) begin
         if (out_ready) begin
            drain_left--;
            if (drain_left == 0) dn = 1;
         end
      end else if (!done_now && start) begin
         if (k_len >= 1 && k_len <= K_MAX) begin
            k_m = int'(k_len);
            if (!(ru && wv_m))
               for (int i = 0; i < ROWS; i++) begin
                  s = '{wen: 1'b1, iben: 1'b0, olen: 1'b0, last_load: (i == ROWS - 1)};
                  sched.push_back(s);
               end
            for (int c = 0; c < LAT + k_m; c++) begin
               s = '{wen: 1'b0, iben: (c < k_m), olen: (c >= LAT), last_load: 1'b0};
               sched.push_back(s);
            end
         end else begin
            cf = 1;
         end
      end
      done_now = dn;
      cfg_now  = cf;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            sched.delete();
            drain_left = 0;
            done_now = 0;
            cfg_now = 0;
            wv_m = 0;
         end else begin
            model_step();
         end
      end
   end

   function automatic logic [8:0] dut_vec();
      return {busy, done, cfg_err, weight_buffer_out_en, write_weight_en,
              input_buffer_out_en, output_buffer_load_en, out_valid, output_buffer_out_en};
   endfunction

   // Per-cycle compare against the model, away from the active edge.
   initial begin
      logic [8:0] exp;
      slot_t      s;
      bit         b, v;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            s = (sched.size() != 0) ? sched[0] : '0;
            b = (sched.size() != 0) || (drain_left != 0) || done_now;
            v = (sched.size() == 0) && (drain_left != 0);
            exp = {b, done_now, cfg_now, s.wen, s.wen, s.iben, s.olen, v, v & out_ready};
            check("cycle_outputs", {23'd0, dut_vec()}, {23'd0, exp});
         end
      end
   end

   logic [31:0] busy_mk, done_mk, cfg_mk, wen_mk, iben_mk, olen_mk, val_mk, oen_mk;

   // Called at posedge+1; cycle 0 is the cycle start_m[0] is presented.
   task automatic run_job(input logic [KW-1:0] k, input logic ru, input logic [31:0] start_m,
                          input logic [31:0] stall_m, input logic [31:0] abort_m, input int n);
      busy_mk = '0; done_mk = '0; cfg_mk = '0; wen_mk = '0;
      iben_mk = '0; olen_mk = '0; val_mk = '0; oen_mk = '0;
      k_len = k;
      reuse_w = ru;
      start = start_m[0];
      out_ready = !stall_m[0];
      abort = abort_m[0];
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         busy_mk[i] = busy;
         done_mk[i] = done;
         cfg_mk[i]  = cfg_err;
         wen_mk[i]  = write_weight_en;
         iben_mk[i] = input_buffer_out_en;
         olen_mk[i] = output_buffer_load_en;
         val_mk[i]  = out_valid;
         oen_mk[i]  = output_buffer_out_en;
         @(posedge clk);
         #1;
         start     = (i + 1 < 32) ? start_m[i+1] : 1'b0;
         out_ready = (i + 1 < 32) ? !stall_m[i+1] : 1'b1;
         abort     = (i + 1 < 32) ? abort_m[i+1] : 1'b0;
      end
      start = 0;
      abort = 0;
      out_ready = 1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      start = 0; abort = 0; out_ready = 1; reuse_w = 0; k_len = '0;
      @(posedge clk);
      #1;
      check("reset_outputs", {23'd0, dut_vec()}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // 1: nominal k=5
      run_job(5'd5, 1'b0, 32'h1, 32'h0, 32'h0, 25);
      check("t1_write_weight_en", wen_mk, 32'h0000_001E);
      check("t1_input_buffer_out_en", iben_mk, 32'h0000_03E0);
      check("t1_output_buffer_load_en", olen_mk, 32'h0001_F000);
      check("t1_output_buffer_out_en", oen_mk, 32'h003E_0000);
      check("t1_done", done_mk, 32'h0040_0000);
      check("t1_busy", busy_mk, 32'h007F_FFFE);

      // 2: k=3 with out_ready low for two cycles after the first beat
      run_job(5'd3, 1'b0, 32'h1, 32'h0003_0000, 32'h0, 23);
      check("t2_output_buffer_out_en", oen_mk, 32'h000C_8000);
      check("t2_out_valid", val_mk, 32'h000F_8000);
      check("t2_done", done_mk, 32'h0010_0000);

      // 3: abort at STREAM c=3, then a normal k=2 job
      run_job(5'd5, 1'b0, 32'h1, 32'h0, 32'h0000_0100, 12);
      check("t3_abort_busy", busy_mk, 32'h0000_01FE);
      check("t3_abort_done", done_mk, 32'h0);
      check("t3_abort_iben", iben_mk, 32'h0000_01E0);
      check("t3_abort_olen", olen_mk, 32'h0);
      run_job(5'd2, 1'b0, 32'h1, 32'h0, 32'h0, 18);
      check("t3_after_iben", iben_mk, 32'h0000_0060);
      check("t3_after_olen", olen_mk, 32'h0000_3000);
      check("t3_after_oen", oen_mk, 32'h0000_C000);
      check("t3_after_done", done_mk, 32'h0001_0000);

      // 4: illegal k_len values, and starts while busy / in DONE
      run_job(5'd0, 1'b0, 32'h1, 32'h0, 32'h0, 3);
      check("t4_k0_cfg_err", cfg_mk, 32'h2);
      check("t4_k0_busy", busy_mk, 32'h0);
      run_job(5'd17, 1'b0, 32'h1, 32'h0, 32'h0, 3);
      check("t4_k17_cfg_err", cfg_mk, 32'h2);
      check("t4_k17_busy", busy_mk, 32'h0);
      run_job(5'd1, 1'b0, 32'h0000_4005, 32'h0, 32'h0, 17);
      check("t4_busy_start_busy", busy_mk, 32'h0000_7FFE);
      check("t4_busy_start_cfg", cfg_mk, 32'h0);
      check("t4_busy_start_done", done_mk, 32'h0000_4000);

      // 5: asynchronous reset in the middle of DRAIN
      run_job(5'd5, 1'b0, 32'h1, 32'h0, 32'h0, 19);
      check("t5_pre_reset_oen", oen_mk, 32'h0006_0000);
      #2;
      rst = 1'b0;
      #1;
      check("t5_async_reset_outputs", {23'd0, dut_vec()}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_job(5'd2, 1'b0, 32'h1, 32'h0, 32'h0, 18);
      check("t5_after_reset_done", done_mk, 32'h0001_0000);

`ifdef SA_SEQ_WEIGHT_REUSE_EN
      // 6: reuse_w right after reset still loads; the next reuse job skips LOAD_W
      do_reset();
      run_job(5'd5, 1'b1, 32'h1, 32'h0, 32'h0, 25);
      check("t6_first_wen", wen_mk, 32'h0000_001E);
      check("t6_first_done", done_mk, 32'h0040_0000);
      run_job(5'd5, 1'b1, 32'h1, 32'h0, 32'h0, 21);
      check("t6_reuse_wen", wen_mk, 32'h0);
      check("t6_reuse_iben", iben_mk, 32'h0000_003E);
      check("t6_reuse_done", done_mk, 32'h0004_0000);
`else
      do_reset();
      run_job(5'd5, 1'b1, 32'h1, 32'h0, 32'h0, 25);
      check("t6_no_reuse_done", done_mk, 32'h0040_0000);
`endif

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
